encrypt_pipe_gather_xor: RTL and testbench

- Encrypt-side counterpart of the decrypt XOR stage.
- Stage 1 applies the bit-gather permutation: bit i of the stage-1 result = din[PERM[i]]. This undoes the decrypt-side scatter.
- Stage 2 XORs the stage-1 result with a rotating key (k1 -> k2 -> k3 -> k1).
- Two-stage valid/ready pipeline with backpressure; sits between the shift/dc encrypt stages and the link output.

---
 rtl/encrypt_pipe_gather_xor_if.sv | 31 +++
 rtl/encrypt_pipe_gather_xor.sv | 160 ++++++++++++++++
 tb/tb_encrypt_pipe_gather_xor.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/encrypt_pipe_gather_xor_if.sv
// Byte stream bus of the encrypt gather/XOR stage: plaintext input side and
// encrypted output side, each a valid/ready pair.
interface encrypt_pipe_gather_xor_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dout;
  logic [1:0] out_key_idx;

  modport slave (
    input  in_valid,
    input  din,
    input  out_ready,
    output in_ready,
    output out_valid,
    output dout,
    output out_key_idx
  );

  modport master (
    output in_valid,
    output din,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  dout,
    input  out_key_idx
  );
endinterface

// File: rtl/encrypt_pipe_gather_xor.sv
// Encrypt-side XOR stage: stage 1 gathers the plaintext bits through PERM,
// stage 2 XORs with a key rotating k1 -> k2 -> k3 every rot_freq+1 bytes.
module encrypt_pipe_gather_xor #(
  parameter logic [23:0] PERM  = 24'o76543210,
  parameter int          CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode_i,
  input  logic [7:0]             k1_i,
  input  logic [7:0]             k2_i,
  input  logic [7:0]             k3_i,
  input  logic [2:0]             rot_freq_i,
  encrypt_pipe_gather_xor_if.slave bus,
  output logic [CNT_W-1:0]       byte_cnt_o
);

  localparam logic [2:0] KEY_SEL_K1 = 3'b001;
  localparam logic [2:0] KEY_SEL_K2 = 3'b010;
  localparam logic [2:0] KEY_SEL_K3 = 3'b100;

  // Output bit i takes input bit PERM[3i+2:3i].
  function automatic logic [7:0] gather(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      r[i] = x[PERM[3*i +: 3]];
    end
    return r;
  endfunction

  function automatic logic [2:0] rotate(input logic [2:0] sel);
    logic [2:0] r;
    case (sel)
      KEY_SEL_K1: r = KEY_SEL_K2;
      KEY_SEL_K2: r = KEY_SEL_K3;
      KEY_SEL_K3: r = KEY_SEL_K1;
      default:    r = KEY_SEL_K1;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] sel_to_idx(input logic [2:0] sel);
    logic [1:0] r;
    case (sel)
      KEY_SEL_K1: r = 2'd1;
      KEY_SEL_K2: r = 2'd2;
      KEY_SEL_K3: r = 2'd3;
      default:    r = 2'd0;
    endcase
    return r;
  endfunction

  logic             s1_v_q,     s1_v_d;
  logic [7:0]       s1_byte_q,  s1_byte_d;
  logic             s2_v_q,     s2_v_d;
  logic [7:0]       dout_q,     dout_d;
  logic [1:0]       key_idx_q,  key_idx_d;
  logic [2:0]       key_sel_q,  key_sel_d;
  logic [2:0]       rot_cnt_q,  rot_cnt_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;

  logic       adv2_s;
  logic       in_ready_s;
  logic       accept_s;
  logic [7:0] key_s;

  // Handshake, key mux and next-state for both stages and the rotation.
  always_comb begin
    adv2_s     = s1_v_q & (~s2_v_q | bus.out_ready);
    // Gated by rst so nothing is offered upstream while held in reset.
    in_ready_s = rst & mode_i & (~s1_v_q | adv2_s);
    accept_s   = bus.in_valid & in_ready_s;

    case (key_sel_q)
      KEY_SEL_K1: key_s = k1_i;
      KEY_SEL_K2: key_s = k2_i;
      KEY_SEL_K3: key_s = k3_i;
      default:    key_s = 8'h00;
    endcase

    s1_v_d     = s1_v_q;
    s1_byte_d  = s1_byte_q;
    s2_v_d     = s2_v_q;
    dout_d     = dout_q;
    key_idx_d  = key_idx_q;
    key_sel_d  = key_sel_q;
    rot_cnt_d  = rot_cnt_q;
    byte_cnt_d = byte_cnt_q;

    if (accept_s) begin
      s1_byte_d = gather(bus.din);
      s1_v_d    = 1'b1;
    end else if (adv2_s) begin
      s1_v_d = 1'b0;
    end else begin
      s1_v_d = s1_v_q;
    end

    if (adv2_s) begin
      dout_d     = s1_byte_q ^ key_s;
      key_idx_d  = sel_to_idx(key_sel_q);
      s2_v_d     = 1'b1;
      byte_cnt_d = byte_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      // The drained byte keeps the current key; idle mode then restarts at k1.
      if (!mode_i) begin
        key_sel_d = KEY_SEL_K1;
        rot_cnt_d = 3'd0;
      end else if (rot_cnt_q == rot_freq_i) begin
        key_sel_d = rotate(key_sel_q);
        rot_cnt_d = 3'd0;
      end else begin
        rot_cnt_d = rot_cnt_q + 3'd1;
      end
    end else begin
      if (bus.out_ready) begin
        s2_v_d = 1'b0;
      end else begin
        s2_v_d = s2_v_q;
      end
      if (!mode_i) begin
        key_sel_d = KEY_SEL_K1;
        rot_cnt_d = 3'd0;
      end else begin
        key_sel_d = key_sel_q;
        rot_cnt_d = rot_cnt_q;
      end
    end
  end

  // Pipeline, output and rotation state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v_q     <= 1'b0;
      s1_byte_q  <= 8'h00;
      s2_v_q     <= 1'b0;
      dout_q     <= 8'h00;
      key_idx_q  <= 2'd1;
      key_sel_q  <= KEY_SEL_K1;
      rot_cnt_q  <= 3'd0;
      byte_cnt_q <= {CNT_W{1'b0}};
    end else begin
      s1_v_q     <= s1_v_d;
      s1_byte_q  <= s1_byte_d;
      s2_v_q     <= s2_v_d;
      dout_q     <= dout_d;
      key_idx_q  <= key_idx_d;
      key_sel_q  <= key_sel_d;
      rot_cnt_q  <= rot_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = s2_v_q;
  assign bus.dout        = dout_q;
  assign bus.out_key_idx = key_idx_q;
  assign byte_cnt_o      = byte_cnt_q;

endmodule

// File: tb/tb_encrypt_pipe_gather_xor.sv
// Bench for encrypt_pipe_gather_xor: identity and bit-reversal instances share
// one stimulus stream and are compared every cycle against a transfer-level model.
module tb_encrypt_pipe_gather_xor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode;
  logic [7:0] k1, k2, k3;
  logic [2:0] rot_freq;
  logic       in_valid;
  logic [7:0] din;
  logic       out_ready;
  logic [15:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  encrypt_pipe_gather_xor_if bus_a ();
  encrypt_pipe_gather_xor_if bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.din       = din;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.din       = din;
  assign bus_b.out_ready = out_ready;

  encrypt_pipe_gather_xor #(.PERM(24'o76543210), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .mode_i(mode), .k1_i(k1), .k2_i(k2), .k3_i(k3),
    .rot_freq_i(rot_freq), .bus(bus_a.slave), .byte_cnt_o(cnt_a));

  encrypt_pipe_gather_xor #(.PERM(24'o01234567), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .mode_i(mode), .k1_i(k1), .k2_i(k2), .k3_i(k3),
    .rot_freq_i(rot_freq), .bus(bus_b.slave), .byte_cnt_o(cnt_b));

  // Model: the pipe holds at most one waiting raw byte and one output byte.
  bit         m_s1v, m_s2v, m_acc;
  logic [7:0] m_s1raw, m_da, m_db;
  logic [1:0] m_kidx;
  int         m_kpos, m_run, m_bcnt;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] obs_a[$];
  logic [7:0] obs_b[$];
  logic [1:0] obs_k[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] gather(input logic [7:0] x, input bit rev);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = rev ? x[7-i] : x[i];
    return r;
  endfunction

  function automatic logic [7:0] key_val(input int pos);
    return (pos == 0) ? k1 : (pos == 1) ? k2 : k3;
  endfunction

  task automatic model_reset();
    m_s1v = 1'b0; m_s2v = 1'b0; m_acc = 1'b0;
    m_s1raw = 8'h00; m_da = 8'h00; m_db = 8'h00;
    m_kidx = 2'd1; m_kpos = 0; m_run = 0; m_bcnt = 0;
  endtask

  task automatic model_update();
    bit adv, ir, acc;
    logic [7:0] key;
    if (!rst) begin
      model_reset();
    end else begin
      adv = m_s1v && (!m_s2v || out_ready);
      ir  = mode && (!m_s1v || adv);
      acc = in_valid && ir;
      if (adv) begin
        key    = key_val(m_kpos);
        m_da   = gather(m_s1raw, 1'b0) ^ key;
        m_db   = gather(m_s1raw, 1'b1) ^ key;
        m_kidx = 2'(m_kpos + 1);
        m_s2v  = 1'b1;
        m_bcnt = (m_bcnt + 1) % 65536;
        if (!mode) begin
          m_kpos = 0; m_run = 0;
        end else if (m_run == int'(rot_freq)) begin
          m_kpos = (m_kpos + 1) % 3; m_run = 0;
        end else begin
          m_run = (m_run + 1) % 8;
        end
      end else begin
        if (out_ready) m_s2v = 1'b0;
        if (!mode) begin
          m_kpos = 0; m_run = 0;
        end
      end
      if (acc) begin
        m_s1raw = din; m_s1v = 1'b1;
      end else if (adv) begin
        m_s1v = 1'b0;
      end
      m_acc = acc;
    end
  endtask

  task automatic check();
    bit e_adv, e_ir;
    e_adv = m_s1v && (!m_s2v || out_ready);
    e_ir  = rst && mode && (!m_s1v || e_adv);
    chk("in_ready",    {31'd0, bus_a.in_ready},    {31'd0, e_ir});
    chk("in_ready_b",  {31'd0, bus_b.in_ready},    {31'd0, e_ir});
    chk("out_valid",   {31'd0, bus_a.out_valid},   {31'd0, m_s2v});
    chk("out_valid_b", {31'd0, bus_b.out_valid},   {31'd0, m_s2v});
    chk("dout_a",      {24'd0, bus_a.dout},        {24'd0, m_da});
    chk("dout_b",      {24'd0, bus_b.dout},        {24'd0, m_db});
    chk("key_idx",     {30'd0, bus_a.out_key_idx}, {30'd0, m_kidx});
    chk("byte_cnt",    {16'd0, cnt_a},             m_bcnt);
    chk("byte_cnt_b",  {16'd0, cnt_b},             m_bcnt);
    if (rst && bus_a.out_valid && out_ready) begin
      obs_a.push_back(bus_a.dout);
      obs_b.push_back(bus_b.dout);
      obs_k.push_back(bus_a.out_key_idx);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    din = b;
    for (int t = 0; t < 50 && !done; t++) begin
      step();
      if (m_acc) done = 1'b1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic reset_pulse();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    model_reset();
    step();
    step();
    rst = 1'b1;
    obs_a.delete(); obs_b.delete(); obs_k.delete();
  endtask

  task automatic chk_obs(input int idx, input logic [7:0] ea, input logic [7:0] eb,
                         input logic [1:0] ek);
    if (idx < obs_a.size()) begin
      chk($sformatf("lit_dout_a[%0d]", idx), {24'd0, obs_a[idx]}, {24'd0, ea});
      chk($sformatf("lit_dout_b[%0d]", idx), {24'd0, obs_b[idx]}, {24'd0, eb});
      chk($sformatf("lit_key[%0d]", idx),    {30'd0, obs_k[idx]}, {30'd0, ek});
    end else begin
      chk($sformatf("lit_missing[%0d]", idx), obs_a.size(), idx + 1);
    end
  endtask

  initial begin
    mode = 1'b0; in_valid = 1'b0; din = 8'h00; out_ready = 1'b1;
    k1 = 8'h00; k2 = 8'h00; k3 = 8'h00; rot_freq = 3'd0;
    model_reset();
    step();
    step();
    chk("rst_key_idx",  {30'd0, bus_a.out_key_idx}, 32'd1);
    chk("rst_in_ready", {31'd0, bus_a.in_ready},    32'd0);
    chk("rst_dout",     {24'd0, bus_a.dout},        32'd0);
    rst = 1'b1; mode = 1'b1;

    // Rotation every byte, back-to-back stream.
    k1 = 8'h11; k2 = 8'h22; k3 = 8'h33; rot_freq = 3'd0;
    obs_a.delete(); obs_b.delete(); obs_k.delete();
    send(8'h00); send(8'h01); send(8'h02); send(8'h03);
    in_valid = 1'b0;
    repeat (4) step();
    chk_obs(0, 8'h11, 8'h11, 2'd1);
    chk_obs(1, 8'h23, 8'hA2, 2'd2);
    chk_obs(2, 8'h31, 8'h73, 2'd3);
    chk_obs(3, 8'h12, 8'hD1, 2'd1);

    // Three bytes per key.
    reset_pulse();
    rot_freq = 3'd2; k1 = 8'hA5; k2 = 8'h5A; k3 = 8'hC3;
    repeat (7) send(8'h00);
    in_valid = 1'b0;
    repeat (4) step();
    chk_obs(0, 8'hA5, 8'hA5, 2'd1);
    chk_obs(2, 8'hA5, 8'hA5, 2'd1);
    chk_obs(3, 8'h5A, 8'h5A, 2'd2);
    chk_obs(5, 8'h5A, 8'h5A, 2'd2);
    chk_obs(6, 8'hC3, 8'hC3, 2'd3);
    chk("lit_byte_cnt7", {16'd0, cnt_a}, 32'd7);

    // Pure permutation with zero keys.
    reset_pulse();
    rot_freq = 3'd0; k1 = 8'h00; k2 = 8'h00; k3 = 8'h00;
    send(8'h01); send(8'hF0);
    in_valid = 1'b0;
    repeat (4) step();
    chk_obs(0, 8'h01, 8'h80, 2'd1);
    chk_obs(1, 8'hF0, 8'h0F, 2'd2);

    // Backpressure: both stages fill, output holds.
    reset_pulse();
    rot_freq = 3'd0; k1 = 8'h11; k2 = 8'h22; k3 = 8'h33;
    out_ready = 1'b0;
    send(8'h10); send(8'h20);
    din = 8'h30;
    repeat (5) begin
      step();
      chk("lit_stall_in_ready", {31'd0, bus_a.in_ready},  32'd0);
      chk("lit_stall_valid",    {31'd0, bus_a.out_valid}, 32'd1);
      chk("lit_stall_dout",     {24'd0, bus_a.dout},      32'h01);
    end
    out_ready = 1'b1;
    send(8'h30); send(8'h40);
    in_valid = 1'b0;
    repeat (5) step();
    chk_obs(0, 8'h01, 8'h19, 2'd1);
    chk_obs(1, 8'h02, 8'h26, 2'd2);
    chk_obs(2, 8'h03, 8'h3F, 2'd3);
    chk_obs(3, 8'h51, 8'h13, 2'd1);

    // Mode drop drains the pipe, then restarts the rotation at k1.
    reset_pulse();
    send(8'h01); send(8'h02);
    mode = 1'b0; in_valid = 1'b0;
    repeat (4) step();
    mode = 1'b1;
    send(8'h03);
    in_valid = 1'b0;
    repeat (3) step();
    chk_obs(0, 8'h10, 8'h91, 2'd1);
    chk_obs(1, 8'h20, 8'h62, 2'd2);
    chk_obs(2, 8'h12, 8'hD1, 2'd1);

    // Reset with both stages full.
    reset_pulse();
    out_ready = 1'b0;
    send(8'hAA); send(8'hBB);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("lit_rst_valid",    {31'd0, bus_a.out_valid}, 32'd0);
    chk("lit_rst_dout",     {24'd0, bus_a.dout},      32'd0);
    chk("lit_rst_cnt",      {16'd0, cnt_a},           32'd0);
    chk("lit_rst_in_ready", {31'd0, bus_a.in_ready},  32'd0);
    model_reset();
    step();
    step();
    rst = 1'b1; out_ready = 1'b1;
    obs_a.delete(); obs_b.delete(); obs_k.delete();
    send(8'h55);
    in_valid = 1'b0;
    repeat (3) step();
    chk_obs(0, 8'h44, 8'hBB, 2'd1);

    // Randomised traffic with live key, rot_freq and mode changes.
    reset_pulse();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      din       = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      k1 = 8'($urandom); k2 = 8'($urandom); k3 = 8'($urandom);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 49) == 0) rot_freq = 3'($urandom);
      step();
    end
    in_valid = 1'b0; mode = 1'b1; out_ready = 1'b1;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
